// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use, MUL/DIV interlock, corrections, interrupts.
// Optional HAZ_PERF_CNT_EN builds the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 5,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_md_start,
  input  logic              id_md_div,
  input  logic              id_md_use,
  input  logic              id_ctrl_xfer,
  input  logic              id_eret,
  input  logic              load_use_stall,
  input  logic              correct_at_ex,
  input  logic              correct_at_mem,
  input  logic              int_req,
  output logic [STAGES-1:0] stage_we,
  output logic [STAGES-1:0] stage_flush,
  output logic              stall,
  output logic              md_busy,
  output logic              exl_set,
  output logic              exl_clr,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  localparam int MDW = $clog2(DIV_CYCLES + 1);
  localparam logic [MDW-1:0] MUL_LD = MDW'(MUL_CYCLES - 1);
  localparam logic [MDW-1:0] DIV_LD = MDW'(DIV_CYCLES - 1);

  logic [MDW-1:0] md_cnt;
  logic [MDW-1:0] md_cnt_nxt;
  logic           int_pending;
  logic           int_pending_nxt;
  logic           busy_raw;
  logic           md_stall;
  logic           stall_raw;
  logic           md_issue;
  logic           take_ok;
  logic           clr_raw;
  logic           set_raw;

  assign busy_raw  = (md_cnt != '0);
  assign md_stall  = id_valid & (id_md_use | id_md_start) & busy_raw;
  assign stall_raw = load_use_stall | md_stall;

  // A correction in MEM kills the ID instruction, so it must not occupy the unit
  assign md_issue = id_valid & id_md_start & !stall_raw & !correct_at_mem;

  assign take_ok = id_valid & !id_ctrl_xfer & !stall_raw
                 & !correct_at_ex & !correct_at_mem;
  assign clr_raw = id_valid & id_eret & !stall_raw & !correct_at_mem;
  assign set_raw = (int_req | int_pending) & take_ok & !clr_raw;

  assign stall   = !reset & stall_raw;
  assign md_busy = !reset & busy_raw;
  assign exl_set = !reset & set_raw;
  assign exl_clr = !reset & clr_raw;

  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_issue) begin
      md_cnt_nxt = id_md_div ? DIV_LD : MUL_LD;
    end else if (busy_raw) begin
      md_cnt_nxt = md_cnt - MDW'(1);
    end
  end

  always_comb begin
    int_pending_nxt = int_pending | int_req;
    if (set_raw) begin
      int_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt      <= '0;
      int_pending <= 1'b0;
    end else begin
      md_cnt      <= md_cnt_nxt;
      int_pending <= int_pending_nxt;
    end
  end

  always_comb begin
    stage_we       = '1;
    stage_flush    = '0;
    stage_we[0]    = !stall_raw;
    stage_we[1]    = !stall_raw;
    stage_flush[1] = set_raw | correct_at_ex | correct_at_mem;
    stage_flush[2] = stall_raw | correct_at_mem;
    if (reset) begin
      stage_we    = '0;
      stage_flush = '1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (stage_flush[1]) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
